// File: rtl/sd_dat_block_rx_pkg.sv
// Shared state encoding and SD DAT bus constants for the block receiver.
package sd_pkg;

   typedef logic [2:0] sd_state_t;

   localparam sd_state_t StIdle      = 3'd0;
   localparam sd_state_t StWaitStart = 3'd1;
   localparam sd_state_t StData      = 3'd2;
   localparam sd_state_t StCrc       = 3'd3;
   localparam sd_state_t StEnd       = 3'd4;
   localparam sd_state_t StDone      = 3'd5;

   localparam logic [15:0] SD_CRC16_POLY   = 16'h1021;
   localparam logic [3:0]  SD_START_NIBBLE = 4'h0;
   localparam logic [3:0]  SD_END_NIBBLE   = 4'hF;

endpackage

// File: rtl/sd_dat_block_rx_if.sv
// Handshake and status bundle between the Avalon-side controller and the DAT read engine.
interface sd_dat_block_rx_if;

   logic       sd_tick;
   logic [3:0] dat_in;
   logic       start;
   logic       abort;
   logic       busy;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       done;
   logic       crc_err;
   logic       end_err;
   logic       timeout;

   modport master (
      output sd_tick, dat_in, start, abort,
      input  busy, rx_data, rx_valid, done, crc_err, end_err, timeout
   );

   modport slave (
      input  sd_tick, dat_in, start, abort,
      output busy, rx_data, rx_valid, done, crc_err, end_err, timeout
   );

endinterface

// File: rtl/sd_dat_block_rx_crc16.sv
// Serial CRC16 for one DAT line: accumulates data bits, then shifts the remainder out MSB first.
module sd_crc16_serial
   import sd_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   input  logic din,
   input  logic shift,
   output logic msb
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      crc_d = crc_q;
      fb    = din ^ crc_q[15];
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         if (shift) begin
            crc_d = {crc_q[14:0], 1'b0};
         end else begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign msb = crc_q[15];

endmodule

// File: rtl/sd_dat_block_rx.sv
// SD 4-bit DAT block read engine: start-bit hunt, nibble-to-byte deserialise, CRC16 and end check.
module sd_dat_block_rx
   import sd_pkg::*;
#(
   parameter int unsigned BLOCK_BYTES   = 512,
   parameter int unsigned TIMEOUT_TICKS = 65535,
   parameter int unsigned TO_W          = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   sd_dat_block_rx_if.slave bus
);

   localparam int unsigned BW = $clog2(BLOCK_BYTES);

   sd_state_t       state_q, state_d;
   logic [BW-1:0]   byte_q, byte_d;
   logic            nib_q, nib_d;
   logic [3:0]      bit_q, bit_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            done_q, done_d;
   logic            crc_err_q, crc_err_d;
   logic            end_err_q, end_err_d;
   logic            timeout_q, timeout_d;

   logic            crc_clr, crc_en, crc_shift;
   logic [3:0]      crc_msb;

   for (genvar i = 0; i < 4; i++) begin : g_crc
      sd_crc16_serial u_crc (
         .clk     (clk),
         .reset_n (reset_n),
         .clr     (crc_clr),
         .en      (crc_en),
         .din     (bus.dat_in[i]),
         .shift   (crc_shift),
         .msb     (crc_msb[i])
      );
   end

   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      nib_d      = nib_q;
      bit_d      = bit_q;
      to_d       = to_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;
      crc_err_d  = crc_err_q;
      end_err_d  = end_err_q;
      timeout_d  = timeout_q;
      crc_clr    = 1'b0;
      crc_en     = 1'b0;
      crc_shift  = 1'b0;

      // Abort beats both start and a coincident tick.
      if (bus.abort) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_d   = StWaitStart;
                  byte_d    = '0;
                  nib_d     = 1'b0;
                  bit_d     = '0;
                  to_d      = '0;
                  crc_err_d = 1'b0;
                  end_err_d = 1'b0;
                  timeout_d = 1'b0;
                  crc_clr   = 1'b1;
               end
            end
            StWaitStart: begin
               if (bus.sd_tick) begin
                  if (bus.dat_in == SD_START_NIBBLE) begin
                     state_d = StData;
                  end else begin
                     to_d = to_q + 1'b1;
                     if (to_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = StIdle;
                     end
                  end
               end
            end
            StData: begin
               if (bus.sd_tick) begin
                  crc_en = 1'b1;
                  if (!nib_q) begin
                     rx_data_d[7:4] = bus.dat_in;
                     nib_d          = 1'b1;
                  end else begin
                     rx_data_d[3:0] = bus.dat_in;
                     nib_d          = 1'b0;
                     rx_valid_d     = 1'b1;
                     if (byte_q == BW'(BLOCK_BYTES - 1)) begin
                        state_d = StCrc;
                        bit_d   = '0;
                     end else begin
                        byte_d = byte_q + 1'b1;
                     end
                  end
               end
            end
            StCrc: begin
               crc_shift = 1'b1;
               if (bus.sd_tick) begin
                  crc_en = 1'b1;
                  if (bus.dat_in != crc_msb) begin
                     crc_err_d = 1'b1;
                  end
                  bit_d = bit_q + 1'b1;
                  if (bit_q == 4'd15) begin
                     state_d = StEnd;
                  end
               end
            end
            StEnd: begin
               if (bus.sd_tick) begin
                  if (bus.dat_in != SD_END_NIBBLE) begin
                     end_err_d = 1'b1;
                  end
                  done_d  = 1'b1;
                  state_d = StDone;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         byte_q     <= '0;
         nib_q      <= 1'b0;
         bit_q      <= '0;
         to_q       <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         crc_err_q  <= 1'b0;
         end_err_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         nib_q      <= nib_d;
         bit_q      <= bit_d;
         to_q       <= to_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         done_q     <= done_d;
         crc_err_q  <= crc_err_d;
         end_err_q  <= end_err_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.busy     = (state_q != StIdle);
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.done     = done_q;
   assign bus.crc_err  = crc_err_q;
   assign bus.end_err  = end_err_q;
   assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_sd_dat_block_rx.sv
// Randomised scoreboard bench for sd_dat_block_rx; CRC expectations come from polynomial division.
module tb_sd_dat_block_rx;

   localparam int unsigned BB = 2048;

   typedef struct {logic [7:0] data; int cyc;} exp_byte_t;
   typedef struct {logic [2:0] st; logic busy; int cyc;} exp_done_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   n_cmp;
   int   n_fail;

   exp_byte_t   exp_q [$];
   exp_done_t   done_q [$];
   logic [7:0]  blk [BB];
   logic [15:0] crcv [4];

   sd_dat_block_rx_if bus ();

   sd_dat_block_rx #(
      .BLOCK_BYTES   (BB),
      .TIMEOUT_TICKS (8),
      .TO_W          (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run did not finish, got time %0t, required < 3000000", $time);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic drv(input logic t, input logic [3:0] d, input logic s, input logic a);
      @(negedge clk);
      bus.sd_tick = t;
      bus.dat_in  = d;
      bus.start   = s;
      bus.abort   = a;
   endtask

   // One sampled nibble, preceded by a random number of unsampled garbage cycles.
   task automatic tk(input logic [3:0] d);
      while ($urandom_range(3) == 0) drv(1'b0, 4'($urandom), 1'b0, 1'b0);
      drv(1'b1, d, 1'b0, 1'b0);
   endtask

   // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1, line bits taken MSB nibble first.
   function automatic logic [15:0] crc_model(input int line);
      logic        bits [$];
      logic [16:0] gen = 17'h11021;
      logic [15:0] r;
      for (int k = 0; k < BB; k++) begin
         bits.push_back(blk[k][4+line]);
         bits.push_back(blk[k][line]);
      end
      repeat (16) bits.push_back(1'b0);
      for (int j = 0; j < 2 * BB; j++) begin
         if (bits[j]) begin
            for (int m = 0; m < 17; m++) bits[j+m] = bits[j+m] ^ gen[16-m];
         end
      end
      for (int m = 0; m < 16; m++) r[15-m] = bits[2*BB+m];
      return r;
   endfunction

   task automatic model_crcs();
      for (int i = 0; i < 4; i++) crcv[i] = crc_model(i);
   endtask

   task automatic send_block(input int n_idle, input logic [3:0] end_nib, input int abort_at,
                             input int flip_line, input int flip_tick);
      logic [3:0] nib;
      exp_byte_t  eb;
      exp_done_t  ed;
      drv(1'b1, 4'h0, 1'b1, 1'b0);  // tick alongside start must be ignored
      repeat (n_idle) tk(4'hF);
      tk(4'h0);
      for (int k = 0; k < BB; k++) begin
         if (k == abort_at) begin
            drv(1'b1, 4'h0, 1'b1, 1'b1);
            drv(1'b0, 4'h0, 1'b0, 1'b0);
            chk("abort_idle", {31'd0, bus.busy}, 32'd0);
            chk("abort_status", {29'd0, bus.crc_err, bus.end_err, bus.timeout}, 32'd0);
            repeat (20) tk(4'($urandom));
            chk("abort_stays_idle", {31'd0, bus.busy}, 32'd0);
            return;
         end
         tk(blk[k][7:4]);
         tk(blk[k][3:0]);
         eb.data = blk[k];
         eb.cyc  = cyc + 1;
         exp_q.push_back(eb);
      end
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < 4; i++) nib[i] = crcv[i][15-b];
         if (b == flip_tick && flip_line >= 0) nib[flip_line] = ~nib[flip_line];
         tk(nib);
      end
      tk(end_nib);
      ed.st   = {flip_line >= 0, end_nib != 4'hF, 1'b0};
      ed.busy = 1'b1;
      ed.cyc  = cyc + 1;
      done_q.push_back(ed);
      repeat (4) drv(1'b0, 4'($urandom), 1'b0, 1'b0);
   endtask

   task automatic monitor();
      exp_byte_t eb;
      exp_done_t ed;
      forever begin
         @(negedge clk);
         if (bus.rx_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rx_valid", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
            end else begin
               eb = exp_q.pop_front();
               chk("rx_data", {24'd0, bus.rx_data}, {24'd0, eb.data});
               chk("rx_valid_cycle", cyc, eb.cyc);
            end
         end
         if (bus.done) begin
            if (done_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               ed = done_q.pop_front();
               chk("done_status", {29'd0, bus.crc_err, bus.end_err, bus.timeout}, {29'd0, ed.st});
               chk("done_busy", {31'd0, bus.busy}, {31'd0, ed.busy});
               chk("done_cycle", cyc, ed.cyc);
            end
         end
      end
   endtask

   initial begin
      exp_done_t ed;
      exp_byte_t eb;
      n_cmp       = 0;
      n_fail      = 0;
      reset_n     = 1'b0;
      bus.sd_tick = 1'b0;
      bus.dat_in  = 4'h0;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {19'd0, bus.busy, bus.rx_data, bus.rx_valid, bus.done,
                            bus.crc_err, bus.end_err, bus.timeout}, 32'd0);
      reset_n = 1'b1;
      fork
         monitor();
      join_none

      // All-zero block, zero CRCs.
      for (int k = 0; k < BB; k++) blk[k] = 8'h00;
      model_crcs();
      send_block(5, 4'hF, -1, -1, 0);

      // All-ones block against the published CRC16 of 4096 one-bits.
      for (int k = 0; k < BB; k++) blk[k] = 8'hFF;
      for (int i = 0; i < 4; i++) crcv[i] = 16'h7FA1;
      send_block(2, 4'hF, -1, -1, 0);
      send_block(0, 4'hF, -1, 2, 3);

      // Random block opening with A,5,3,C.
      for (int k = 0; k < BB; k++) blk[k] = 8'($urandom);
      blk[0] = 8'hA5;
      blk[1] = 8'h3C;
      model_crcs();
      send_block(3, 4'hF, -1, -1, 0);

      // Bad end nibble.
      for (int k = 0; k < BB; k++) blk[k] = 8'($urandom);
      model_crcs();
      send_block(1, 4'h7, -1, -1, 0);

      // Abort partway, then a clean block.
      send_block(0, 4'hF, 100, -1, 0);
      for (int k = 0; k < BB; k++) blk[k] = 8'($urandom);
      model_crcs();
      send_block(4, 4'hF, -1, -1, 0);

      // Timeout after eight non-start ticks.
      drv(1'b1, 4'h0, 1'b1, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         tk(4'($urandom_range(15, 1)));
         if (i == 8) begin
            ed.st   = 3'b001;
            ed.busy = 1'b0;
            ed.cyc  = cyc + 1;
            done_q.push_back(ed);
         end
      end
      repeat (4) drv(1'b0, 4'h0, 1'b0, 1'b0);
      chk("timeout_idle", {31'd0, bus.busy}, 32'd0);

      // Reset asserted mid-DATA.
      drv(1'b1, 4'h0, 1'b1, 1'b0);
      tk(4'h0);
      for (int k = 0; k < 10; k++) begin
         eb.data = 8'($urandom_range(255, 1));
         tk(eb.data[7:4]);
         tk(eb.data[3:0]);
         eb.cyc = cyc + 1;
         exp_q.push_back(eb);
      end
      repeat (3) drv(1'b0, 4'h0, 1'b0, 1'b0);
      chk("busy_mid_data", {31'd0, bus.busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("reset_mid_data", {19'd0, bus.busy, bus.rx_data, bus.rx_valid, bus.done,
                             bus.crc_err, bus.end_err, bus.timeout}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) drv(1'b1, 4'($urandom), 1'b0, 1'b0);
      chk("post_reset_idle", {31'd0, bus.busy}, 32'd0);

      chk("bytes_outstanding", exp_q.size(), 32'd0);
      chk("done_outstanding", done_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
